// File: rtl/gcode_char_fetcher_if.sv
// Byte-FIFO read port plus subparser read handshake for the G-code character fetcher.
// The master modport is the fetcher; slave is the FIFO/subparser side.
interface gcode_char_fetcher_if;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic       rd_trigger;
  logic       rd_done;
  logic       rd_rdy;
  logic       is_empty;
  logic [7:0] char_out;

  modport master (
    input  fifo_data, fifo_empty, rd_trigger,
    output fifo_rd_en, rd_done, rd_rdy, is_empty, char_out
  );

  modport slave (
    output fifo_data, fifo_empty, rd_trigger,
    input  fifo_rd_en, rd_done, rd_rdy, is_empty, char_out
  );
endinterface

// File: rtl/gcode_char_fetcher.sv
// Pops raw bytes from the receive FIFO, drops comments and CRs, folds case, and
// hands one meaningful character per rd_trigger to the subparsers.
module gcode_char_fetcher #(
  parameter bit STRIP_COMMENTS = 1'b1,
  parameter bit CASE_FOLD      = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  gcode_char_fetcher_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_FILTER,
    S_DONE
  } state_t;

  localparam logic [7:0] C_CR    = 8'h0D;
  localparam logic [7:0] C_LF    = 8'h0A;
  localparam logic [7:0] C_SEMI  = 8'h3B;
  localparam logic [7:0] C_LPAR  = 8'h28;
  localparam logic [7:0] C_RPAR  = 8'h29;

  state_t     r_state;
  logic [7:0] r_raw;
  logic [7:0] r_char;
  logic       r_in_line;
  logic       r_in_paren;
  logic [7:0] w_folded;
  logic       w_is_lower;

  assign w_is_lower = (r_raw >= 8'h61) && (r_raw <= 8'h7A);
  assign w_folded   = (CASE_FOLD && w_is_lower) ? (r_raw - 8'h20) : r_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_raw      <= 8'h00;
      r_char     <= 8'h00;
      r_in_line  <= 1'b0;
      r_in_paren <= 1'b0;
    end else if (clk_en) begin
      case (r_state)
        S_IDLE:   if (bus.rd_trigger) r_state <= S_READ;
        S_READ:   if (!bus.fifo_empty) r_state <= S_WAIT;
        S_WAIT: begin
          r_raw   <= bus.fifo_data;
          r_state <= S_FILTER;
        end
        S_FILTER: begin
          // Rule order matters: a newline always closes any open comment.
          if (r_raw == C_CR) begin
            r_state <= S_READ;
          end else if (r_raw == C_LF) begin
            r_in_line  <= 1'b0;
            r_in_paren <= 1'b0;
            r_char     <= w_folded;
            r_state    <= S_DONE;
          end else if (STRIP_COMMENTS && r_in_line) begin
            r_state <= S_READ;
          end else if (STRIP_COMMENTS && r_in_paren) begin
            if (r_raw == C_RPAR) r_in_paren <= 1'b0;
            r_state <= S_READ;
          end else if (STRIP_COMMENTS && (r_raw == C_SEMI)) begin
            r_in_line <= 1'b1;
            r_state   <= S_READ;
          end else if (STRIP_COMMENTS && (r_raw == C_LPAR)) begin
            r_in_paren <= 1'b1;
            r_state    <= S_READ;
          end else begin
            r_char  <= w_folded;
            r_state <= S_DONE;
          end
        end
        S_DONE:   r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Gating the pop with clk_en keeps FIFO and fetcher in lockstep while frozen.
  assign bus.fifo_rd_en = (r_state == S_READ) && clk_en && !bus.fifo_empty;
  assign bus.rd_done    = (r_state == S_DONE);
  assign bus.rd_rdy     = (r_state == S_IDLE);
  assign bus.is_empty   = bus.fifo_empty;
  assign bus.char_out   = r_char;

endmodule

// File: doc/gcode_char_fetcher.md
Name: gcode_char_fetcher

Overview:
- Upstream feeder for the argument and opcode subparsers; implements the read side of the subparser interface (rd_trigger / rd_done / rd_rdy / is_empty) plus the char_in byte.
- Pops raw bytes from the receive byte FIFO (1-cycle read latency) and folds lowercase to uppercase.
- Strips G-code comments (';' to end of line, '(' ... ')') and carriage returns, so subparsers only ever see meaningful characters and '\n'.

Parameters:
STRIP_COMMENTS, 1, 1 = discard comment bytes; 0 = pass every byte except '\r'.
CASE_FOLD, 1, 1 = map 'a'..'z' to 'A'..'Z' on delivery.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-high reset.
clk_en  input  1  module enabling clock; all state frozen when low.
fifo_data  input  8  FIFO read data, valid the cycle after a pop.
fifo_empty  input  1  FIFO empty flag.
fifo_rd_en  output  1  FIFO pop strobe.
rd_trigger  input  1  subparser requests next character.
rd_done  output  1  character delivered on char_out.
rd_rdy  output  1  fetcher idle, can accept rd_trigger.
is_empty  output  1  no raw byte available (mirrors fifo_empty).
char_out  output  8  delivered character, drives subparser char_in.

Behaviour:
- Reset (async, any state): state IDLE, char_out=8'h00, rd_done=0, fifo_rd_en=0, raw register=0, in_line_comment=0, in_paren_comment=0. rd_rdy=1 after reset.
- FSM states: IDLE, READ, WAIT, FILTER, DONE. All transitions and register updates occur only on clk edges with clk_en=1.
- IDLE: rd_rdy=1. rd_trigger=1 -> READ. rd_trigger is ignored in every other state.
- READ: fifo_rd_en = clk_en & ~fifo_empty.
  - fifo_empty=1: stay in READ (stall, no pop).
  - Otherwise: -> WAIT.
- WAIT: capture fifo_data into raw register; -> FILTER.
- FILTER: classify raw byte, evaluating rules in this order:
  - '\r' (8'h0D): discard; -> READ.
  - '\n' (8'h0A): clear both comment flags; deliver.
  - STRIP_COMMENTS=1 and in_line_comment: discard; -> READ.
  - STRIP_COMMENTS=1 and in_paren_comment: if ')', clear flag; discard either way; -> READ.
  - STRIP_COMMENTS=1 and ';': set in_line_comment; discard; -> READ.
  - STRIP_COMMENTS=1 and '(': set in_paren_comment; discard; -> READ.
  - Else deliver.
- Deliver:
  - char_out <= raw, mapped +(-8'h20) if CASE_FOLD=1 and raw is in 8'h61..8'h7A; -> DONE.
  - char_out changes only on delivery and holds between deliveries.
- DONE: rd_done=1, rd_rdy=0; next enabled edge -> IDLE. rd_done is high for exactly one enabled cycle.
- rd_rdy = (state==IDLE), combinational. is_empty = fifo_empty, combinational.
- Minimum latency, FIFO non-empty, no discards: trigger sampled at edge 0 -> READ in cycle 1 (pop) -> WAIT cycle 2 -> FILTER cycle 3 -> rd_done high in cycle 4.
- Each discarded byte adds 3 cycles.
- Comment flags persist across triggers until '\n' arrives.
- A '\n' inside a paren comment is delivered and closes the comment (malformed-line recovery).
- ')' outside a comment and ';' / '(' when STRIP_COMMENTS=0 are delivered unchanged.
- clk_en low: state, flags and outputs hold; fifo_rd_en is forced 0 so no pop is lost or duplicated. rd_done stays high if frozen in DONE.
- Reset mid-fetch: a byte already popped but not delivered is dropped; comment state is cleared.

Test Plan:
- FIFO holds "g1\n", three triggers -> char_out 8'h47 ('G'), 8'h31, 8'h0A. Each rd_done arrives 4 cycles after its trigger; exactly 3 pops.
- FIFO holds "X5;move\nY" with STRIP_COMMENTS=1, triggers until 'Y' -> delivered 'X','5','\n','Y'. The ';move' bytes (5) are popped but never asserted on rd_done.
- FIFO holds "(c)Z\r\n" -> delivered 'Z', '\n'. In-paren and '\r' bytes are discarded; the 'Z' rd_done is 4+3*3=13 cycles after its trigger.
- Trigger with fifo_empty=1 for 10 cycles, then push 'F' -> fifo_rd_en stays 0 while empty; one pop follows, then rd_done with char_out 8'h46.
- clk_en toggled 1/0 every cycle during a fetch of 'a' -> exactly one pop, char_out 8'h41. Latency doubles; rd_done is sampled high on exactly one enabled edge.
- Reset asserted during WAIT while in_line_comment=1 -> outputs return to reset values immediately. The next fetch of 'M' delivers 8'h4D (flag cleared).
